// File: rtl/qar_mem_arb_pkg.sv
// Shared types and constants for the qar_mem_arbiter instruction/data memory arbiter.
package qar_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    REQ_IMEM = 1'b0,
    REQ_DMEM = 1'b1
  } req_id_e;

  localparam logic [63:0] ERR_RDATA = 64'h0;

endpackage

// File: rtl/qar_bus_timeout.sv
// Bus wait-state watchdog: cleared by start, counts ticks, flags the tick that reaches TIMEOUT_CYCLES.
module qar_bus_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic        EN    = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // expired is combinational so the FSM leaves BUS on the very tick that hits the limit
  assign expired = EN && tick && !start && (cnt_q == CNT_W'(LAST));

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (EN && tick && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/qar_mem_arbiter.sv
// Two-requester (imem/dmem) arbiter onto one shared memory port with a wait-state timeout.
// Define QAR_MEM_ARB_RR_EN for round-robin ties; otherwise dmem always wins a tie.
module qar_mem_arbiter
  import qar_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_valid,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_ready,
  output logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  dmem_valid,
  input  logic                  dmem_we,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic                  dmem_ready,
  output logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  bus_valid,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ready,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_err,
  output logic                  busy
);

  state_e                state_q, state_d;
  req_id_e               owner_q, owner_d;
  logic                  bus_valid_q, bus_valid_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic                  imem_ready_q, imem_ready_d;
  logic                  dmem_ready_q, dmem_ready_d;
  logic [DATA_WIDTH-1:0] imem_rdata_q, imem_rdata_d;
  logic [DATA_WIDTH-1:0] dmem_rdata_q, dmem_rdata_d;
  logic                  bus_err_q, bus_err_d;
  logic                  busy_q, busy_d;

  logic                  grant_dmem_c;
  logic                  tmo_start_c, tmo_tick_c, tmo_expired_c;
  logic [DATA_WIDTH-1:0] resp_rdata_c;

`ifdef QAR_MEM_ARB_RR_EN
  req_id_e last_q, last_d;
  // Whoever was granted last loses the next tie.
  assign grant_dmem_c = dmem_valid && (!imem_valid || (last_q == REQ_IMEM));
`else
  assign grant_dmem_c = dmem_valid;
`endif

  assign tmo_start_c = (state_q == IDLE) && (imem_valid || dmem_valid);
  assign tmo_tick_c  = (state_q == BUS) && !bus_ready;

  qar_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .start  (tmo_start_c),
    .tick   (tmo_tick_c),
    .expired(tmo_expired_c)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    bus_valid_d  = bus_valid_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    imem_ready_d = 1'b0;
    dmem_ready_d = 1'b0;
    imem_rdata_d = '0;
    dmem_rdata_d = '0;
    bus_err_d    = 1'b0;
    resp_rdata_c = '0;
`ifdef QAR_MEM_ARB_RR_EN
    last_d       = last_q;
`endif

    case (state_q)
      IDLE: begin
        if (imem_valid || dmem_valid) begin
          state_d     = BUS;
          bus_valid_d = 1'b1;
          if (grant_dmem_c) begin
            owner_d     = REQ_DMEM;
            bus_we_d    = dmem_we;
            bus_addr_d  = dmem_addr;
            bus_wdata_d = dmem_wdata;
          end else begin
            owner_d     = REQ_IMEM;
            bus_we_d    = 1'b0;
            bus_addr_d  = imem_addr;
            bus_wdata_d = '0;
          end
`ifdef QAR_MEM_ARB_RR_EN
          last_d = grant_dmem_c ? REQ_DMEM : REQ_IMEM;
`endif
        end
      end
      BUS: begin
        // A real bus_ready always beats a timeout landing in the same cycle.
        if (bus_ready || tmo_expired_c) begin
          state_d     = RESP;
          bus_valid_d = 1'b0;
          bus_err_d   = !bus_ready;
          if (!bus_ready) begin
            resp_rdata_c = DATA_WIDTH'(ERR_RDATA);
          end else if (!bus_we_q) begin
            resp_rdata_c = bus_rdata;
          end
          imem_ready_d = (owner_q == REQ_IMEM);
          dmem_ready_d = (owner_q == REQ_DMEM);
          imem_rdata_d = (owner_q == REQ_IMEM) ? resp_rdata_c : '0;
          dmem_rdata_d = (owner_q == REQ_DMEM) ? resp_rdata_c : '0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= REQ_DMEM;
      bus_valid_q  <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      imem_ready_q <= 1'b0;
      dmem_ready_q <= 1'b0;
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
      bus_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      bus_valid_q  <= bus_valid_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      imem_ready_q <= imem_ready_d;
      dmem_ready_q <= dmem_ready_d;
      imem_rdata_q <= imem_rdata_d;
      dmem_rdata_q <= dmem_rdata_d;
      bus_err_q    <= bus_err_d;
      busy_q       <= busy_d;
    end
  end

`ifdef QAR_MEM_ARB_RR_EN
  // Reset value makes dmem win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_IMEM;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign bus_valid  = bus_valid_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign imem_ready = imem_ready_q;
  assign dmem_ready = dmem_ready_q;
  assign imem_rdata = imem_rdata_q;
  assign dmem_rdata = dmem_rdata_q;
  assign bus_err    = bus_err_q;
  assign busy       = busy_q;

endmodule

// File: doc/qar_mem_arbiter.md
QAR_MEM_ARBITER -- requirements
Module: qar_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of all address buses.
REQ-002 Parameter DATA_WIDTH, default 32: width of all data buses.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum cycles waiting for bus_ready; 0 disables the timeout.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 imem_valid  in  1  instruction fetch request, held until imem_ready.
REQ-008 imem_addr  in  ADDR_WIDTH  fetch byte address.
REQ-009 imem_ready  out  1  one-cycle fetch completion pulse.
REQ-010 imem_rdata  out  DATA_WIDTH  fetched word, valid while imem_ready=1.
REQ-011 dmem_valid, dmem_we  in  1 each  data request and write enable, held until dmem_ready.
REQ-012 dmem_addr  in  ADDR_WIDTH; dmem_wdata  in  DATA_WIDTH  data request address and write data.
REQ-013 dmem_ready  out  1; dmem_rdata  out  DATA_WIDTH  data completion pulse and read word.
REQ-014 bus_valid, bus_we  out  1 each; bus_addr  out  ADDR_WIDTH; bus_wdata  out  DATA_WIDTH  shared memory port request.
REQ-015 bus_ready  in  1; bus_rdata  in  DATA_WIDTH  shared port completion and read data; bus_ready may be combinational from bus_valid.
REQ-016 bus_err  out  1  one-cycle timeout pulse, coincident with the requester's ready.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, BUS and RESP.
REQ-019 In IDLE, if any *_valid=1, the block SHALL register the winner's address, we and wdata, and record the winner's identity.
- imem requests always register bus_we=0 and bus_wdata=0.
- Transition to BUS.
REQ-020 In BUS, bus_valid=1 and the registered fields SHALL stay stable until the cycle bus_valid&&bus_ready.
- In that cycle: capture bus_rdata (0 for writes) and go to RESP.
REQ-021 In RESP, exactly the recorded requester's *_ready SHALL be 1 with the captured rdata for one cycle.
- Next state is IDLE; requests are not sampled in RESP, so a held valid is never served twice.
REQ-022 Latency: request sampled in IDLE at cycle N gives bus_valid at N+1; with zero wait states, *_ready at N+2.
- Maximum throughput: one access per 3 cycles.
REQ-023 The non-granted requester SHALL see *_ready=0 and stay pending; it is arbitrated on the next IDLE.
REQ-024 Timeout: a counter SHALL clear on entry to BUS and increment each BUS cycle without bus_ready.
- On reaching TIMEOUT_CYCLES: drop bus_valid, go to RESP with rdata=0 and bus_err=1 in the RESP cycle.
- When TIMEOUT_CYCLES=0 the timeout SHALL never fire.
REQ-025 Outputs in IDLE: bus_valid=0, imem_ready=0, dmem_ready=0, bus_err=0.
- imem_rdata/dmem_rdata SHALL be 0 when the matching ready is 0.
REQ-026 Requesters changing addr/wdata after grant SHALL have no effect on the in-flight access.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL enter IDLE.
- bus_valid, bus_we, bus_addr, bus_wdata, all ready/rdata outputs, bus_err, busy and the timeout counter SHALL clear to 0.
- The round-robin pointer SHALL reset to favour dmem.
REQ-028 Reset in BUS or RESP SHALL abandon the access without any ready pulse; a bus_ready arriving in the reset cycle is ignored.

Configuration
REQ-029 Macro QAR_MEM_ARB_RR_EN: when defined, arbitration SHALL be round-robin.
- The requester granted last loses the next tie.
- A 1-bit pointer updates on each grant.
REQ-030 Without QAR_MEM_ARB_RR_EN, dmem SHALL always win a tie (fixed priority) and no pointer register exists.

Structure
REQ-031 Package qar_mem_arb_pkg SHALL hold the FSM state typedef (IDLE/BUS/RESP), the requester-id typedef (REQ_IMEM/REQ_DMEM) and the rdata-on-error constant (0).
REQ-032 The timeout counter SHALL be a sub-module qar_bus_timeout with ports clk, rst, start, tick and expired.
- It is parameterised by TIMEOUT_CYCLES.

Verification
REQ-033 imem read at 0x10, bus_ready combinational, bus_rdata=0x00000013:
- bus_valid=1 with bus_addr=0x10 at N+1.
- imem_ready=1, imem_rdata=0x13 at N+2 for one cycle only.
REQ-034 imem and dmem both valid in the same IDLE cycle, dmem read 0x80 and imem read 0x04:
- Fixed build: dmem is served first, then imem.
- RR build: four back-to-back simultaneous pairs alternate dmem, imem, dmem, imem...
REQ-035 dmem write to 0x40 with 0xCAFEBABE and three wait states:
- bus_we=1, bus_addr=0x40 and bus_wdata=0xCAFEBABE held for 4 cycles.
- dmem_ready then pulses once with dmem_rdata=0.
REQ-036 TIMEOUT_CYCLES=4, dmem read with bus_ready stuck at 0:
- bus_valid drops after 4 BUS cycles.
- dmem_ready=1, bus_err=1, dmem_rdata=0 in the same cycle.
REQ-037 rst pulsed while bus_valid=1:
- All outputs are 0 in the next cycle and no ready pulse occurs.
- A fresh imem request afterwards completes normally.
